// File: rtl/m_mux_2in1out_arbiter_pkg.sv
// rtl/m_mux_2in1out_arbiter_pkg.sv - shared state encoding and input index constants for the 2:1 flit arbiter
package m_mux_2in1out_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY0 = 2'd1,
        S_BUSY1 = 2'd2
    } state_t;

    localparam logic IDX_0 = 1'b0;
    localparam logic IDX_1 = 1'b1;

    function automatic logic [1:0] onehot2(input logic idx);
        return (idx == IDX_1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/m_rr_pick2.sv
// rtl/m_rr_pick2.sv - combinational 2-way round-robin picker returning a one-hot winner
module m_rr_pick2
    import m_mux_2in1out_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] pick
);

    // A lone requester wins outright; prio only breaks a tie.
    assign pick = (req == 2'b11) ? onehot2(prio) : req;

endmodule

// File: rtl/m_mux_2in1out_arbiter.sv
// rtl/m_mux_2in1out_arbiter.sv - wormhole round-robin arbiter driving the select of a 2:1 flit mux
module m_mux_2in1out_arbiter
    import m_mux_2in1out_arbiter_pkg::*;
#(
    parameter int P_CNT_WIDTH = 8,
    parameter int P_INIT_PRIO = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_0,
    input  logic                   in_head_0,
    input  logic                   in_tail_0,
    output logic                   in_ready_0,
    input  logic                   in_valid_1,
    input  logic                   in_head_1,
    input  logic                   in_tail_1,
    output logic                   in_ready_1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   select,
    output logic [1:0]             grant,
    output logic                   pkt_done,
    output logic [P_CNT_WIDTH-1:0] pkt_len,
    output logic                   err_seq
);

    localparam logic                   INIT_PRIO = (P_INIT_PRIO != 0) ? IDX_1 : IDX_0;
    localparam logic [P_CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [P_CNT_WIDTH-1:0] CNT_ONE   = P_CNT_WIDTH'(1);

    state_t                 state, state_nxt;
    logic                   prio, prio_nxt;
    logic                   select_nxt;
    logic [1:0]             grant_nxt;
    logic [P_CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc, len_nxt;
    logic                   done_nxt, err_nxt;
    logic [1:0]             req, pick;
    logic                   own_valid, own_head, own_tail;

    assign req = {in_valid_1 & in_head_1, in_valid_0 & in_head_0};

    m_rr_pick2 u_pick (
        .req  (req),
        .prio (prio),
        .pick (pick)
    );

    // select is stable for the whole packet, so it doubles as the owner index.
    assign own_valid = select ? in_valid_1 : in_valid_0;
    assign own_head  = select ? in_head_1  : in_head_0;
    assign own_tail  = select ? in_tail_1  : in_tail_0;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_comb begin
        state_nxt  = state;
        prio_nxt   = prio;
        select_nxt = select;
        grant_nxt  = grant;
        cnt_nxt    = cnt;
        len_nxt    = pkt_len;
        done_nxt   = 1'b0;
        err_nxt    = err_seq;
        out_valid  = 1'b0;
        in_ready_0 = 1'b0;
        in_ready_1 = 1'b0;
        case (state)
            S_IDLE: begin
                if ((in_valid_0 & ~in_head_0) | (in_valid_1 & ~in_head_1))
                    err_nxt = 1'b1;
                if (pick != 2'b00) begin
                    state_nxt  = pick[1] ? S_BUSY1 : S_BUSY0;
                    select_nxt = pick[1];
                    grant_nxt  = pick;
                    cnt_nxt    = '0;
                end
            end
            S_BUSY0, S_BUSY1: begin
                out_valid = own_valid;
                if (select) in_ready_1 = out_ready;
                else        in_ready_0 = out_ready;
                if (own_valid & out_ready) begin
                    cnt_nxt = cnt_inc;
                    // A nonzero count means this is not the packet's first flit.
                    if (own_head && (cnt != '0))
                        err_nxt = 1'b1;
                    if (own_tail) begin
                        state_nxt = S_IDLE;
                        grant_nxt = 2'b00;
                        prio_nxt  = ~select;
                        done_nxt  = 1'b1;
                        len_nxt   = cnt_inc;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            prio     <= INIT_PRIO;
            select   <= INIT_PRIO;
            grant    <= 2'b00;
            cnt      <= '0;
            pkt_done <= 1'b0;
            pkt_len  <= '0;
            err_seq  <= 1'b0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            select   <= select_nxt;
            grant    <= grant_nxt;
            cnt      <= cnt_nxt;
            pkt_done <= done_nxt;
            pkt_len  <= len_nxt;
            err_seq  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_m_mux_2in1out_arbiter.sv
// tb/tb_m_mux_2in1out_arbiter.sv - table-driven and directed checks for the 2:1 wormhole arbiter
module tb_m_mux_2in1out_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_0 = 0, in_head_0 = 0, in_tail_0 = 0;
    logic       in_valid_1 = 0, in_head_1 = 0, in_tail_1 = 0;
    logic       out_ready = 0;
    logic       in_ready_0, in_ready_1, out_valid, select, pkt_done, err_seq;
    logic [1:0] grant;
    logic [7:0] pkt_len;
    logic       in_ready_0_b, in_ready_1_b, out_valid_b, select_b, pkt_done_b, err_seq_b;
    logic [1:0] grant_b;
    logic [1:0] pkt_len_b;

    always #5 clk = ~clk;

    m_mux_2in1out_arbiter #(.P_CNT_WIDTH(8), .P_INIT_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid_0(in_valid_0), .in_head_0(in_head_0), .in_tail_0(in_tail_0), .in_ready_0(in_ready_0),
        .in_valid_1(in_valid_1), .in_head_1(in_head_1), .in_tail_1(in_tail_1), .in_ready_1(in_ready_1),
        .out_valid(out_valid), .out_ready(out_ready), .select(select), .grant(grant),
        .pkt_done(pkt_done), .pkt_len(pkt_len), .err_seq(err_seq)
    );

    m_mux_2in1out_arbiter #(.P_CNT_WIDTH(2), .P_INIT_PRIO(0)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid_0(in_valid_0), .in_head_0(in_head_0), .in_tail_0(in_tail_0), .in_ready_0(in_ready_0_b),
        .in_valid_1(in_valid_1), .in_head_1(in_head_1), .in_tail_1(in_tail_1), .in_ready_1(in_ready_1_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .select(select_b), .grant(grant_b),
        .pkt_done(pkt_done_b), .pkt_len(pkt_len_b), .err_seq(err_seq_b)
    );

    typedef struct {
        string       name;
        logic        rst, v0, h0, t0, v1, h1, t1, ordy;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   xfer1 = 0;
    int   done_cnt = 0;

    always @(posedge clk) if (in_valid_1 && in_ready_1) xfer1++;
    always @(negedge clk) if (pkt_done) done_cnt++;

    function automatic void add(input string n, input bit r,
                                input bit v0, input bit h0, input bit t0,
                                input bit v1, input bit h1, input bit t1, input bit ordy,
                                input bit ov, input bit r0, input bit r1, input bit sel,
                                input bit [1:0] g, input bit d, input bit [7:0] l, input bit e);
        vec_t x;
        x.name = n; x.rst = r;
        x.v0 = v0; x.h0 = h0; x.t0 = t0;
        x.v1 = v1; x.h1 = h1; x.t1 = t1; x.ordy = ordy;
        x.exp = {ov, r0, r1, sel, g, d, l, e};
        vecs.push_back(x);
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input bit v0, input bit h0, input bit t0,
                         input bit v1, input bit h1, input bit t1, input bit ordy);
        in_valid_0 = v0; in_head_0 = h0; in_tail_0 = t0;
        in_valid_1 = v1; in_head_1 = h1; in_tail_1 = t1;
        out_ready  = ordy;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            drive(vecs[i].v0, vecs[i].h0, vecs[i].t0, vecs[i].v1, vecs[i].h1, vecs[i].t1, vecs[i].ordy);
            #1;
            check(vecs[i].name,
                  {16'd0, out_valid, in_ready_0, in_ready_1, select, grant, pkt_done, pkt_len, err_seq},
                  {16'd0, vecs[i].exp});
        end
    endtask

    int n1, n2, n3, n4, mark;

    initial begin
        // fields: name rst | v0 h0 t0 v1 h1 t1 ordy | ov r0 r1 sel grant done len err
        add("t1_rst",   1, 0,0,0, 0,0,0, 1, 0,0,0,0, 2'b00, 0, 8'd0, 0);
        add("t1_req",   0, 1,1,0, 0,0,0, 1, 0,0,0,0, 2'b00, 0, 8'd0, 0);
        add("t1_head",  0, 1,1,0, 0,0,0, 1, 1,1,0,0, 2'b01, 0, 8'd0, 0);
        add("t1_body",  0, 1,0,0, 0,0,0, 1, 1,1,0,0, 2'b01, 0, 8'd0, 0);
        add("t1_tail",  0, 1,0,1, 0,0,0, 1, 1,1,0,0, 2'b01, 0, 8'd0, 0);
        add("t1_done",  0, 0,0,0, 0,0,0, 1, 0,0,0,0, 2'b00, 1, 8'd3, 0);
        add("t1_idle",  0, 0,0,0, 0,0,0, 1, 0,0,0,0, 2'b00, 0, 8'd3, 0);
        add("t1_preq",  0, 1,1,0, 1,1,0, 1, 0,0,0,0, 2'b00, 0, 8'd3, 0);
        add("t1_pgnt",  0, 1,1,0, 1,1,0, 0, 1,0,0,1, 2'b10, 0, 8'd3, 0);
        n1 = vecs.size();
        add("t2_rst",   1, 0,0,0, 0,0,0, 1, 0,0,0,0, 2'b00, 0, 8'd0, 0);
        add("t2_req",   0, 1,1,0, 1,1,0, 1, 0,0,0,0, 2'b00, 0, 8'd0, 0);
        add("t2_h0",    0, 1,1,0, 1,1,0, 1, 1,1,0,0, 2'b01, 0, 8'd0, 0);
        add("t2_t0",    0, 1,0,1, 1,1,0, 1, 1,1,0,0, 2'b01, 0, 8'd0, 0);
        add("t2_gap",   0, 0,0,0, 1,1,0, 1, 0,0,0,0, 2'b00, 1, 8'd2, 0);
        add("t2_h1",    0, 0,0,0, 1,1,0, 1, 1,0,1,1, 2'b10, 0, 8'd2, 0);
        add("t2_t1",    0, 0,0,0, 1,0,1, 1, 1,0,1,1, 2'b10, 0, 8'd2, 0);
        add("t2_done",  0, 0,0,0, 0,0,0, 1, 0,0,0,1, 2'b00, 1, 8'd2, 0);
        n2 = vecs.size();
        add("t3_req",   0, 0,0,0, 1,1,0, 1, 0,0,0,1, 2'b00, 0, 8'd2, 0);
        add("t3_head",  0, 0,0,0, 1,1,0, 1, 1,0,1,1, 2'b10, 0, 8'd2, 0);
        add("t3_stl0",  0, 0,0,0, 1,0,0, 0, 1,0,0,1, 2'b10, 0, 8'd2, 0);
        add("t3_stl1",  0, 0,0,0, 1,0,0, 0, 1,0,0,1, 2'b10, 0, 8'd2, 0);
        add("t3_body1", 0, 0,0,0, 1,0,0, 1, 1,0,1,1, 2'b10, 0, 8'd2, 0);
        add("t3_body2", 0, 0,0,0, 1,0,0, 1, 1,0,1,1, 2'b10, 0, 8'd2, 0);
        add("t3_stl2",  0, 0,0,0, 1,0,1, 0, 1,0,0,1, 2'b10, 0, 8'd2, 0);
        add("t3_tail",  0, 0,0,0, 1,0,1, 1, 1,0,1,1, 2'b10, 0, 8'd2, 0);
        add("t3_done",  0, 0,0,0, 0,0,0, 1, 0,0,0,1, 2'b00, 1, 8'd4, 0);
        n3 = vecs.size();
        add("t4_body",  0, 1,0,0, 0,0,0, 1, 0,0,0,1, 2'b00, 0, 8'd4, 0);
        add("t4_err",   0, 1,0,0, 0,0,0, 1, 0,0,0,1, 2'b00, 0, 8'd4, 1);
        add("t4_hold",  0, 0,0,0, 0,0,0, 1, 0,0,0,1, 2'b00, 0, 8'd4, 1);
        n4 = vecs.size();

        mark = done_cnt;
        run(0, n1);
        check("t1_done_pulses", done_cnt - mark, 1);
        mark = done_cnt;
        run(n1, n2);
        check("t2_done_pulses", done_cnt - mark, 2);
        mark = xfer1;
        run(n2, n3);
        check("t3_xfers", xfer1 - mark, 4);
        run(n3, n4);

        // reset in the middle of a 5-flit packet, after its 2nd flit
        @(negedge clk); drive(0,0,0, 0,0,0, 1); #1;
        check("t5_err_sticky", err_seq, 1);
        @(negedge clk); drive(1,1,0, 0,0,0, 1);
        @(negedge clk); drive(1,1,0, 0,0,0, 1);
        @(negedge clk); drive(1,0,0, 0,0,0, 1);
        @(negedge clk); drive(1,0,0, 0,0,0, 1); #1;
        check("t5_busy", {out_valid, grant}, 3'b101);
        #1 rst = 1'b1; #1;
        check("t5_async_rst",
              {16'd0, out_valid, in_ready_0, in_ready_1, select, grant, pkt_done, pkt_len, err_seq}, 0);
        mark = done_cnt;
        @(negedge clk); rst = 1'b0; drive(0,0,0, 0,0,0, 1);
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt - mark, 0);
        drive(0,0,0, 1,1,1, 1); #1;
        check("t5_idle_gnt", grant, 2'b00);
        @(negedge clk); #1;
        check("t5_grant1", {grant, select, out_valid, in_ready_1}, 5'b10111);
        @(negedge clk); drive(0,0,0, 0,0,0, 1); #1;
        check("t5_single", {grant, pkt_done, pkt_len}, {2'b00, 1'b1, 8'd1});

        // 6-flit packet: 8-bit counter reports 6, 2-bit counter saturates at 3
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; drive(1,1,0, 0,0,0, 1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); drive(1, i == 1, i == 6, 0,0,0, 1);
        end
        @(negedge clk); drive(0,0,0, 0,0,0, 1); #1;
        check("t6_len8", {pkt_done, pkt_len}, {1'b1, 8'd6});
        check("t6_len_sat", {pkt_done_b, pkt_len_b}, {1'b1, 2'd3});

        // a second head inside a packet is flagged but still forwarded
        @(negedge clk); drive(1,1,0, 0,0,0, 1);
        @(negedge clk); drive(1,1,0, 0,0,0, 1);
        @(negedge clk); drive(1,1,0, 0,0,0, 1); #1;
        check("t7_first_head_ok", err_seq, 0);
        @(negedge clk); drive(1,0,1, 0,0,0, 1); #1;
        check("t7_mid_head_err", {err_seq, out_valid, in_ready_0}, 3'b111);
        @(negedge clk); drive(0,0,0, 0,0,0, 1); #1;
        check("t7_done", {pkt_done, pkt_len, err_seq}, {1'b1, 8'd3, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m_mux_2in1out_arbiter.md
Name: m_mux_2in1out_arbiter

Overview:
- Packet-level (wormhole) round-robin arbiter that drives the `select` input of the 2-input/1-output flit mux in the router datapath.
- Grants one of two requesting input streams on a head flit and holds the grant until that stream's tail flit is accepted downstream.
- Gates valid/ready between the two inputs and the single output.
- Reports per-packet flit count and a sticky protocol-error flag.

Parameters:
- P_CNT_WIDTH, 8, width of the per-packet flit counter `pkt_len`; the counter saturates at all-ones.
- P_INIT_PRIO, 0, input index (0 or 1) with priority after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid_0  input  1  input 0 flit valid.
- in_head_0  input  1  input 0 flit is a head flit.
- in_tail_0  input  1  input 0 flit is a tail flit; head and tail together mean a single-flit packet.
- in_ready_0  output  1  input 0 flit accepted this cycle when valid.
- in_valid_1, in_head_1, in_tail_1  input  1 each  same meaning, input 1.
- in_ready_1  output  1  same meaning, input 1.
- out_valid  output  1  muxed flit valid toward downstream.
- out_ready  input  1  downstream accepts the flit.
- select  output  1  registered mux select: 0 passes data_in_0, 1 passes data_in_1.
- grant  output  2  one-hot current owner; 00 when idle.
- pkt_done  output  1  one-cycle pulse registered after a tail flit transfers.
- pkt_len  output  P_CNT_WIDTH  flit count of the packet just completed; valid while pkt_done=1, held afterwards.
- err_seq  output  1  sticky protocol-error flag; cleared only by rst.

Behaviour:
- Reset values: state=IDLE, prio=P_INIT_PRIO, select=P_INIT_PRIO, grant=00, out_valid=0, in_ready_0=in_ready_1=0, pkt_done=0, pkt_len=0, internal counter=0, err_seq=0.
- State machine has three states: IDLE, BUSY0, BUSY1.
- IDLE:
  - out_valid=0 and both in_ready=0.
  - Requester k is eligible when in_valid_k & in_head_k.
  - If both are eligible, grant goes to `prio`. If only one is eligible, grant goes to that one.
  - On grant: next state BUSYk, select<=k, grant<=onehot(k), counter<=0.
  - Arbitration latency is one cycle: the head flit transfers no earlier than the cycle after the request is seen.
  - A valid non-head flit on any input in IDLE sets err_seq. That flit is not accepted and no grant is issued for it.
- BUSYk:
  - out_valid = in_valid_k.
  - in_ready_k = out_ready.
  - in_ready of the other input = 0.
  - All three are combinational from inputs and state; select is static during the packet.
  - A transfer occurs when in_valid_k & out_ready.
  - Each transfer increments the counter, saturating at 2^P_CNT_WIDTH-1.
  - Transfer of a tail flit:
    - next state IDLE, grant<=00, prio<=1-k;
    - pkt_done<=1 next cycle, pkt_len<=counter+1 (saturated).
  - select retains its last value in IDLE.
  - A head flit transferred in BUSYk after the first flit of the packet sets err_seq. It is still passed through.
- The losing requester stalls with ready=0 and must hold its valid (standard valid/ready).
- Round-robin fairness: with both inputs streaming back-to-back packets, grants alternate 0,1,0,1.
- Single-flit packet: grant in cycle N, transfer in N+1 (if out_ready=1), IDLE in N+2, next grant decided in N+2.
- out_ready low in BUSY: state, counter and select hold; no flit is lost or duplicated.
- Reset asserted mid-packet: immediate return to IDLE with reset values; the partial packet is abandoned and pkt_done is not pulsed.
- No combinational path from in_* to select or grant.

Decomposition:
- Shared package (parameters include file):
  - state encoding constants S_IDLE=2'd0, S_BUSY0=2'd1, S_BUSY1=2'd2;
  - the input index constants.
- Sub-module m_rr_pick2: combinational 2-way round-robin picker, inputs req[1:0] and prio, output one-hot pick.
- The mux instance stays outside this block; top-level router wiring connects select to it.

Test Plan:
- Reset, then only input 0 sends a 3-flit packet (H,B,T) with out_ready=1:
  - grant=01 and select=0 one cycle after the head is presented;
  - three transfers on consecutive cycles;
  - pkt_done pulse with pkt_len=3;
  - grant=00; next prio=1.
- Both inputs present head flits simultaneously after reset (P_INIT_PRIO=0), each sending 2-flit packets:
  - input 0 served first, then input 1;
  - in_ready_1=0 throughout input 0's packet;
  - grant sequence 01,00,10;
  - two pkt_done pulses with pkt_len=2.
- Input 1 holds a 4-flit packet while out_ready toggles 1,0,0,1,1,0,1:
  - exactly 4 transfers;
  - select stays 1;
  - pkt_len=4;
  - no transfer while out_ready=0.
- Body flit (head=0) presented valid in IDLE → err_seq=1 next cycle, in_ready stays 0, grant=00; err_seq stays 1 until rst.
- Assert rst after the 2nd flit of a 5-flit packet:
  - all outputs return to reset values asynchronously;
  - no pkt_done pulse;
  - a new head on input 1 afterwards is granted normally.
- P_CNT_WIDTH=2, 6-flit packet → pkt_len saturates at 3.
